// File: rtl/mem_stage_sram_ctrl_if.sv
// Bus bundle between the EXE/MEM pipeline side, the memory-stage controller
// and the off-chip 16-bit SRAM.
// Optional macro MEM_ALIGN_CHECK_EN adds the misalign status line.
interface mem_stage_sram_ctrl_if #(
  parameter int WORD_WIDTH      = 32,
  parameter int SRAM_DATA_WIDTH = 16,
  parameter int SRAM_ADDR_WIDTH = 18
);
  logic                       mem_read;
  logic                       mem_write;
  logic [WORD_WIDTH-1:0]      addr;
  logic [WORD_WIDTH-1:0]      wdata;
  logic [WORD_WIDTH-1:0]      rdata;
  logic                       ready;
  logic                       freeze;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
  logic [SRAM_DATA_WIDTH-1:0] sram_wdata;
  logic [SRAM_DATA_WIDTH-1:0] sram_rdata;
  logic                       sram_we_n;
  logic                       sram_oe_n;
`ifdef MEM_ALIGN_CHECK_EN
  logic                       misalign;

  modport slave (
    input  mem_read, mem_write, addr, wdata, sram_rdata,
    output rdata, ready, freeze, sram_addr, sram_wdata, sram_we_n, sram_oe_n,
    output misalign
  );

  modport master (
    output mem_read, mem_write, addr, wdata, sram_rdata,
    input  rdata, ready, freeze, sram_addr, sram_wdata, sram_we_n, sram_oe_n,
    input  misalign
  );
`else
  modport slave (
    input  mem_read, mem_write, addr, wdata, sram_rdata,
    output rdata, ready, freeze, sram_addr, sram_wdata, sram_we_n, sram_oe_n
  );

  modport master (
    output mem_read, mem_write, addr, wdata, sram_rdata,
    input  rdata, ready, freeze, sram_addr, sram_wdata, sram_we_n, sram_oe_n
  );
`endif
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage SRAM controller: splits one 32-bit load/store into a low and a
// high 16-bit SRAM access, each lasting WAIT_CYCLES clocks, and freezes the
// pipeline until the pair completes. ready pulses for one cycle in DONE.
// Optional macro MEM_ALIGN_CHECK_EN: unaligned requests skip the SRAM and
// finish immediately with misalign=1.
module mem_stage_sram_ctrl #(
  parameter int WORD_WIDTH      = 32,
  parameter int SRAM_DATA_WIDTH = 16,
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int BASE_ADDR       = 1024,
  parameter int WAIT_CYCLES     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_stage_sram_ctrl_if.slave    bus
);

  localparam int IDX_W = SRAM_ADDR_WIDTH - 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // SRAM word index of a CPU byte address; subtraction wraps modulo 2^WORD_WIDTH
  // so addresses below BASE_ADDR alias the top of the SRAM.
  function automatic logic [IDX_W-1:0] word_index(input logic [WORD_WIDTH-1:0] a);
    return IDX_W'((a - WORD_WIDTH'(BASE_ADDR)) >> 2);
  endfunction

  state_t                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [IDX_W-1:0]           idx_q;
  logic [SRAM_DATA_WIDTH-1:0] wdata_hi_q;
  logic                       is_wr_q;
  logic [WORD_WIDTH-1:0]      rdata_q;
  logic                       ready_q;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q;
  logic [SRAM_DATA_WIDTH-1:0] sram_wdata_q;
  logic                       we_n_q;
  logic                       oe_n_q;
  logic                       req;
`ifdef MEM_ALIGN_CHECK_EN
  logic                       misalign_q;
  logic                       addr_unaligned;

  assign addr_unaligned = |bus.addr[1:0];
  assign bus.misalign   = misalign_q;
`endif

  assign req        = bus.mem_read | bus.mem_write;
  assign bus.freeze = req & ~ready_q;

  assign bus.rdata      = rdata_q;
  assign bus.ready      = ready_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_oe_n  = oe_n_q;

  // Access sequencer: IDLE -> LO -> HI -> DONE with registered SRAM strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      wdata_hi_q   <= '0;
      is_wr_q      <= 1'b0;
      rdata_q      <= '0;
      ready_q      <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (req) begin
            // A simultaneous read and write is treated as a write.
            is_wr_q    <= bus.mem_write;
            idx_q      <= word_index(bus.addr);
            wdata_hi_q <= bus.wdata[WORD_WIDTH-1:SRAM_DATA_WIDTH];
`ifdef MEM_ALIGN_CHECK_EN
            if (addr_unaligned) begin
              // Reject without touching the SRAM; report in DONE.
              ready_q    <= 1'b1;
              misalign_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              cnt_q        <= CNT_LOAD;
              sram_addr_q  <= {word_index(bus.addr), 1'b0};
              sram_wdata_q <= bus.wdata[SRAM_DATA_WIDTH-1:0];
              we_n_q       <= ~bus.mem_write;
              oe_n_q       <= bus.mem_write;
              state_q      <= LO;
            end
`else
            cnt_q        <= CNT_LOAD;
            sram_addr_q  <= {word_index(bus.addr), 1'b0};
            sram_wdata_q <= bus.wdata[SRAM_DATA_WIDTH-1:0];
            we_n_q       <= ~bus.mem_write;
            oe_n_q       <= bus.mem_write;
            state_q      <= LO;
`endif
          end
        end

        LO: begin
          if (cnt_q == '0) begin
            if (!is_wr_q) begin
              rdata_q[SRAM_DATA_WIDTH-1:0] <= bus.sram_rdata;
            end
            cnt_q        <= CNT_LOAD;
            sram_addr_q  <= {idx_q, 1'b1};
            sram_wdata_q <= wdata_hi_q;
            state_q      <= HI;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        HI: begin
          if (cnt_q == '0) begin
            if (!is_wr_q) begin
              rdata_q[WORD_WIDTH-1:SRAM_DATA_WIDTH] <= bus.sram_rdata;
            end
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        DONE: begin
          // The pipeline advances on this edge, so the held request is not restarted.
          ready_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
          misalign_q <= 1'b0;
`endif
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: behavioural SRAM, table of load/store
// vectors run back-to-back through a scoreboard, then hand-written idle,
// reset-mid-access and (with MEM_ALIGN_CHECK_EN) misalign sequences.
module tb_mem_stage_sram_ctrl;

  localparam int W = 2;

  logic clk;
  logic rst;

  mem_stage_sram_ctrl_if #(
    .WORD_WIDTH(32), .SRAM_DATA_WIDTH(16), .SRAM_ADDR_WIDTH(18)
  ) bus ();

  mem_stage_sram_ctrl #(
    .WORD_WIDTH(32), .SRAM_DATA_WIDTH(16), .SRAM_ADDR_WIDTH(18),
    .BASE_ADDR(1024), .WAIT_CYCLES(W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          frz;
    int          we;
    int          oe;
  } exp_t;

  logic [15:0] mem [0:262143];
  exp_t        sb_q [$];
  vec_t        vecs [10];
  int          we_cnt;
  int          oe_cnt;
  int          n_chk;
  int          n_fail;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mis_seen;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: combinational read while oe_n is low, write on each edge with we_n low.
  assign bus.sram_rdata = bus.sram_oe_n ? 16'h0000 : mem[bus.sram_addr];

  always @(posedge clk) begin
    if (!bus.sram_we_n) mem[bus.sram_addr] <= bus.sram_wdata;
    if (!bus.sram_we_n) we_cnt <= we_cnt + 1;
    if (!bus.sram_oe_n) oe_cnt <= oe_cnt + 1;
  end

  function automatic logic [17:0] lo_addr(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return {off[18:2], 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request at posedge+1, count freeze cycles until ready, compare against scoreboard.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input int exp_frz, input int exp_we, input int exp_oe);
    exp_t        e;
    int          cyc;
    int          fcnt;
    int          we0;
    int          oe0;
    bit          got;
    logic [31:0] rd_at;
    e.rdata = exp_rd;
    e.frz   = exp_frz;
    e.we    = exp_we;
    e.oe    = exp_oe;
    sb_q.push_back(e);
    we0 = we_cnt;
    oe0 = oe_cnt;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.wdata     = wd;
    cyc   = 0;
    fcnt  = 0;
    got   = 0;
    rd_at = 'x;
    while (!got && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (bus.freeze) fcnt++;
      if (bus.ready) begin
        got   = 1;
        rd_at = bus.rdata;
`ifdef MEM_ALIGN_CHECK_EN
        mis_seen = bus.misalign;
`endif
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: got no ready in %0d cycles, required ready", cyc);
    end
    e = sb_q.pop_front();
    check("freeze_cycles", fcnt, e.frz);
    check("ready_cycle", cyc, e.frz + 1);
    check("rdata", rd_at, e.rdata);
    check("we_cycles", we_cnt - we0, e.we);
    check("oe_cycles", oe_cnt - oe0, e.oe);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    we_cnt = 0;
    oe_cnt = 0;

    vecs[0] = '{1'b0, 1'b1, 32'd1024,     32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1024,     32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'd1028,     32'h12345678, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 32'd1028,     32'h00000000, 32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 32'd1032,     32'h0000A5A5, 32'h12345678};
    vecs[5] = '{1'b1, 1'b0, 32'd1032,     32'h00000000, 32'h0000A5A5};
    vecs[6] = '{1'b0, 1'b1, 32'd1020,     32'hCAFEF00D, 32'h0000A5A5};
    vecs[7] = '{1'b1, 1'b0, 32'd1020,     32'h00000000, 32'hCAFEF00D};
    vecs[8] = '{1'b0, 1'b1, 32'h00080400, 32'h0BADC0DE, 32'hCAFEF00D};
    vecs[9] = '{1'b1, 1'b0, 32'd1024,     32'h00000000, 32'h0BADC0DE};

    rst           = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_ready", bus.ready, 1'b0);
    check("rst_freeze", bus.freeze, 1'b0);
    check("rst_sram_addr", bus.sram_addr, 18'h0);
    check("rst_sram_wdata", bus.sram_wdata, 16'h0);
    check("rst_we_n", bus.sram_we_n, 1'b1);
    check("rst_oe_n", bus.sram_oe_n, 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
    check("rst_misalign", bus.misalign, 1'b0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // No request: nothing may move.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_we_n", bus.sram_we_n, 1'b1);
      check("idle_oe_n", bus.sram_oe_n, 1'b1);
      check("idle_freeze", bus.freeze, 1'b0);
      check("idle_ready", bus.ready, 1'b0);
    end
    @(posedge clk);
    #1;

    // Table vectors, issued back-to-back.
    for (int i = 0; i < 10; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                1 + 2 * W, vecs[i].wr ? 2 * W : 0, vecs[i].wr ? 0 : 2 * W);
`ifdef MEM_ALIGN_CHECK_EN
      check("vec_misalign", mis_seen, 1'b0);
`endif
      if (vecs[i].wr) begin
        check("mem_lo", {16'h0, mem[lo_addr(vecs[i].addr)]}, {16'h0, vecs[i].wdata[15:0]});
        check("mem_hi", {16'h0, mem[lo_addr(vecs[i].addr) | 18'd1]}, {16'h0, vecs[i].wdata[31:16]});
      end
    end

    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    check("freeze_after_drop", bus.freeze, 1'b0);
    @(posedge clk);
    #1;

    // Reset in the middle of the low half of a write.
    bus.mem_write = 1'b1;
    bus.addr      = 32'd1040;
    bus.wdata     = 32'h11112222;
    @(posedge clk);
    @(negedge clk);
    check("midwr_we_n_low", bus.sram_we_n, 1'b0);
    check("midwr_addr", bus.sram_addr, lo_addr(32'd1040));
    rst = 1'b1;
    #1;
    check("midwr_we_n_async", bus.sram_we_n, 1'b1);
    check("midwr_oe_n_async", bus.sram_oe_n, 1'b1);
    check("midwr_ready", bus.ready, 1'b0);
    check("midwr_freeze_held", bus.freeze, 1'b1);
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    #1;
    check("midwr_freeze_drop", bus.freeze, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_we_n", bus.sram_we_n, 1'b1);
    check("post_rst_ready", bus.ready, 1'b0);
    check("post_rst_rdata", bus.rdata, 32'h0);
    @(posedge clk);
    #1;

    // Recovery: a normal read after the abandoned write.
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, 32'h0BADC0DE, 1 + 2 * W, 0, 2 * W);

`ifdef MEM_ALIGN_CHECK_EN
    // Unaligned read completes in cycle 2 with no SRAM activity and rdata kept.
    do_access(1'b1, 1'b0, 32'd1025, 32'h0, 32'h0BADC0DE, 1, 0, 0);
    check("unaligned_misalign", mis_seen, 1'b1);
    bus.mem_read = 1'b0;
    @(negedge clk);
    check("misalign_clears", bus.misalign, 1'b0);
`endif

    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Memory-stage controller between the EXE/MEM pipeline register and the MEM/WB register.
- Converts one 32-bit load/store into two sequential 16-bit accesses on the off-chip SRAM.
- Each access uses fixed wait states.
- Drives a freeze signal that stalls the whole pipeline until the access completes, then presents load data to writeback.

Parameters:
- WORD_WIDTH, 32, CPU data/address width
- SRAM_DATA_WIDTH, 16, external SRAM data bus width
- SRAM_ADDR_WIDTH, 18, external SRAM halfword address width
- BASE_ADDR, 1024, CPU byte address mapped to SRAM word 0
- WAIT_CYCLES, 2, clocks per SRAM half access; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_read  in  1  load request from EXE/MEM register
- mem_write  in  1  store request from EXE/MEM register
- addr  in  WORD_WIDTH  byte address (ALU result)
- wdata  in  WORD_WIDTH  store data (Rm value)
- rdata  out  WORD_WIDTH  load data, registered
- ready  out  1  access complete this cycle
- freeze  out  1  pipeline stall request, combinational
- sram_addr  out  SRAM_ADDR_WIDTH  SRAM halfword address
- sram_wdata  out  SRAM_DATA_WIDTH  SRAM write data
- sram_rdata  in  SRAM_DATA_WIDTH  SRAM read data
- sram_we_n  out  1  SRAM write enable, active low
- sram_oe_n  out  1  SRAM output enable, active low

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values: state IDLE; rdata 0; ready 0; sram_addr 0; sram_wdata 0; sram_we_n 1; sram_oe_n 1; wait counter 0.
- req = mem_read | mem_write. If both are asserted, the access is a write; rdata is unchanged.
- freeze = req & ~ready. The upstream pipeline holds addr, wdata, mem_read and mem_write stable while freeze=1.
- Address mapping: word_idx = (addr - BASE_ADDR) >> 2, truncated to SRAM_ADDR_WIDTH-1 bits. Low half is at {word_idx,0}; high half is at {word_idx,1}.
- FSM states: IDLE, LO, HI, DONE.
- IDLE: if req, latch addr, wdata and access type; load counter with WAIT_CYCLES-1; go to LO. Otherwise stay in IDLE.
- LO:
  - drive sram_addr = {word_idx,0}.
  - write: sram_wdata = wdata[15:0], sram_we_n = 0.
  - read: sram_oe_n = 0.
  - Counter decrements each cycle. When it reaches 0:
    - read: capture sram_rdata into rdata[15:0].
    - reload counter and go to HI.
- HI: same as LO, using address {word_idx,1} and data bits [31:16]. At count 0, a read captures rdata[31:16]; go to DONE.
- DONE: ready = 1 for exactly one cycle; SRAM strobes inactive; go to IDLE unconditionally. The pipeline advances on this edge, so the held request is never restarted.
- Latency: freeze is high for 1 + 2*WAIT_CYCLES cycles; ready rises in the following cycle (6th cycle for WAIT_CYCLES=2).
- Back-to-back accesses: a new req seen in IDLE immediately after DONE starts a fresh access. There is no idle gap beyond the IDLE cycle.
- No request: no SRAM strobe ever asserts; freeze = 0.
- rdata holds its last captured value until the next read overwrites it. A half-completed read never leaves a partial update visible, because ready is not asserted.
- Reset mid-access: FSM returns to IDLE. sram_we_n and sram_oe_n go to 1 asynchronously, and the access is abandoned.
- Address arithmetic wraps modulo 2^WORD_WIDTH. Addresses below BASE_ADDR alias high SRAM words; no error is flagged unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - adds output misalign (1 bit, reset 0).
  - In IDLE, a req with addr[1:0] != 0 skips LO/HI: no SRAM strobes, FSM goes straight to DONE.
  - In DONE, ready=1 and misalign=1 for that one cycle; rdata is unchanged.
  - freeze is high for 1 cycle.
- Undefined: no misalign port; addr[1:0] is ignored and the access proceeds normally.

Test Plan:
- Reset during LO of a write (sram_we_n=0) -> sram_we_n=1 immediately; next cycle state IDLE, ready=0, freeze follows req.
- Write addr=1024, wdata=0xDEADBEEF, WAIT_CYCLES=2 -> halfword 0 = 0xBEEF, halfword 1 = 0xDEAD; freeze high 5 cycles; ready pulses once in cycle 6.
- Read addr=1024 after that write -> rdata=0xDEADBEEF when ready=1; sram_we_n stays 1 throughout.
- Back-to-back write 1028/0x12345678 then read 1028 -> two complete sequences; read returns 0x12345678; no lost or repeated access.
- mem_read=mem_write=1, addr=1032, wdata=0xA5A5 -> write performed; rdata keeps its previous value.
- No request for 10 cycles -> sram_we_n=sram_oe_n=1, freeze=0, ready=0; with MEM_ALIGN_CHECK_EN, read addr=1025 -> no strobes, ready=misalign=1 in cycle 2.
